// File: rtl/fpu_shared_arbiter.sv
// Round-robin arbiter that shares one FPU between NUM_REQ cores.
// Registers the winning operation, waits for the FPU result (or a watchdog timeout) and returns it to the owner.
module fpu_shared_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int C_OP    = 32,
    parameter int C_RM    = 3,
    parameter int C_CMD   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*C_OP-1:0]    operand_a_i,
    input  logic [NUM_REQ*C_OP-1:0]    operand_b_i,
    input  logic [NUM_REQ*C_RM-1:0]    rounding_mode_i,
    input  logic [NUM_REQ*C_CMD-1:0]   operator_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [NUM_REQ-1:0]         rvalid_o,
    output logic [C_OP-1:0]            result_o,
    output logic                       err_o,
    output logic                       busy_o,
    output logic [C_OP-1:0]            fpu_operand_a_o,
    output logic [C_OP-1:0]            fpu_operand_b_o,
    output logic [C_RM-1:0]            fpu_rm_o,
    output logic [C_CMD-1:0]           fpu_op_o,
    output logic                       fpu_enable_o,
    output logic                       fpu_stall_o,
    input  logic [C_OP-1:0]            fpu_result_i,
    input  logic                       fpu_valid_i
);

    localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state_q, state_d;
    logic [RW-1:0]        rr_q, rr_d;
    logic [RW-1:0]        owner_q, owner_d;
    logic [7:0]           timer_q, timer_d;
    logic [C_OP-1:0]      fpu_a_q, fpu_a_d;
    logic [C_OP-1:0]      fpu_b_q, fpu_b_d;
    logic [C_RM-1:0]      fpu_rm_q, fpu_rm_d;
    logic [C_CMD-1:0]     fpu_op_q, fpu_op_d;
    logic [C_OP-1:0]      result_q, result_d;
    logic [NUM_REQ-1:0]   rvalid_q, rvalid_d;
    logic                 err_q, err_d;

    logic [C_OP-1:0]      op_a  [NUM_REQ];
    logic [C_OP-1:0]      op_b  [NUM_REQ];
    logic [C_RM-1:0]      op_rm [NUM_REQ];
    logic [C_CMD-1:0]     op_op [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign op_a[gi]  = operand_a_i[gi*C_OP +: C_OP];
            assign op_b[gi]  = operand_b_i[gi*C_OP +: C_OP];
            assign op_rm[gi] = rounding_mode_i[gi*C_RM +: C_RM];
            assign op_op[gi] = operator_i[gi*C_CMD +: C_CMD];
        end
    endgenerate

    // First requester at or after the round-robin pointer, wrapping modulo NUM_REQ.
    logic [RW-1:0] win;
    logic          any_req;
    logic [RW:0]   scan_idx;

    always_comb begin
        win      = '0;
        any_req  = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_q} + (RW+1)'(k);
            if (scan_idx >= (RW+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (RW+1)'(NUM_REQ);
            end
            if (!any_req && req_i[scan_idx[RW-1:0]]) begin
                any_req = 1'b1;
                win     = scan_idx[RW-1:0];
            end
        end
    end

    logic [RW-1:0] owner_next;
    assign owner_next = (owner_q == RW'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        owner_d  = owner_q;
        timer_d  = timer_q;
        fpu_a_d  = fpu_a_q;
        fpu_b_d  = fpu_b_q;
        fpu_rm_d = fpu_rm_q;
        fpu_op_d = fpu_op_q;
        result_d = result_q;
        rvalid_d = '0;
        err_d    = 1'b0;
        gnt_o    = '0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_o[win] = 1'b1;
                    fpu_a_d    = op_a[win];
                    fpu_b_d    = op_b[win];
                    fpu_rm_d   = op_rm[win];
                    fpu_op_d   = op_op[win];
                    owner_d    = win;
                    timer_d    = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                timer_d = timer_q + 8'd1;
                // A real result wins over the watchdog when both land in the same cycle.
                if (fpu_valid_i) begin
                    result_d          = fpu_result_i;
                    rvalid_d[owner_q] = 1'b1;
                    rr_d              = owner_next;
                    state_d           = IDLE;
                end else if (timer_q == 8'(TIMEOUT-1)) begin
                    result_d          = '0;
                    rvalid_d[owner_q] = 1'b1;
                    err_d             = 1'b1;
                    rr_d              = owner_next;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            owner_q  <= '0;
            timer_q  <= '0;
            fpu_a_q  <= '0;
            fpu_b_q  <= '0;
            fpu_rm_q <= '0;
            fpu_op_q <= '0;
            result_q <= '0;
            rvalid_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
            timer_q  <= timer_d;
            fpu_a_q  <= fpu_a_d;
            fpu_b_q  <= fpu_b_d;
            fpu_rm_q <= fpu_rm_d;
            fpu_op_q <= fpu_op_d;
            result_q <= result_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    // Enable drops in IDLE so the FPU wrapper's own cycle counter can return to idle.
    assign fpu_enable_o    = (state_q == BUSY);
    assign busy_o          = (state_q == BUSY);
    assign fpu_stall_o     = 1'b0;
    assign fpu_operand_a_o = fpu_a_q;
    assign fpu_operand_b_o = fpu_b_q;
    assign fpu_rm_o        = fpu_rm_q;
    assign fpu_op_o        = fpu_op_q;
    assign result_o        = result_q;
    assign rvalid_o        = rvalid_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_fpu_shared_arbiter.sv
// Scoreboard bench for fpu_shared_arbiter: a cycle-level reference model predicts grants and completions,
// a monitor pops expectations whenever the DUT presents rvalid_o.
module tb_fpu_shared_arbiter;

    localparam int N  = 4;
    localparam int TO = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_i;
    logic [N*32-1:0]   operand_a_i;
    logic [N*32-1:0]   operand_b_i;
    logic [N*3-1:0]    rounding_mode_i;
    logic [N*4-1:0]    operator_i;
    logic [N-1:0]      gnt_o;
    logic [N-1:0]      rvalid_o;
    logic [31:0]       result_o;
    logic              err_o;
    logic              busy_o;
    logic [31:0]       fpu_operand_a_o;
    logic [31:0]       fpu_operand_b_o;
    logic [2:0]        fpu_rm_o;
    logic [3:0]        fpu_op_o;
    logic              fpu_enable_o;
    logic              fpu_stall_o;
    logic [31:0]       fpu_result_i;
    logic              fpu_valid_i;

    fpu_shared_arbiter #(.NUM_REQ(N), .C_OP(32), .C_RM(3), .C_CMD(4), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i),
        .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
        .rounding_mode_i(rounding_mode_i), .operator_i(operator_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .result_o(result_o), .err_o(err_o), .busy_o(busy_o),
        .fpu_operand_a_o(fpu_operand_a_o), .fpu_operand_b_o(fpu_operand_b_o),
        .fpu_rm_o(fpu_rm_o), .fpu_op_o(fpu_op_o), .fpu_enable_o(fpu_enable_o),
        .fpu_stall_o(fpu_stall_o), .fpu_result_i(fpu_result_i), .fpu_valid_i(fpu_valid_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // FPU behaviour: single-precision add for normal operands (op 0), otherwise a fixed scramble.
    function automatic real sp2real(input logic [31:0] x);
        logic [63:0] d;
        d = {x[31], 11'({3'b0, x[30:23]} + 11'd896), x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        e = d[62:52];
        if (e < 11'd897 || e > 11'd1150) return 32'd0;
        return {d[63], 8'(e - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op, input logic [2:0] rm);
        if (op == 4'd0 && a[30:23] != 8'd0 && a[30:23] != 8'hFF && b[30:23] != 8'd0 && b[30:23] != 8'hFF)
            return real2sp(sp2real(a) + sp2real(b));
        return a ^ {b[15:0], b[31:16]} ^ {25'd0, op, rm};
    endfunction

    typedef struct {
        logic [N-1:0] onehot;
        logic [31:0]  result;
        logic         err;
        int           cyc;
    } exp_t;

    exp_t        sb[$];
    int          lat_r [N];     // 0 = FPU never answers
    int          cur_lat = 0;
    logic [N-1:0] gnt_seen = '0;
    int          m_rr = 0;
    bit          m_busy = 0;
    int          m_done = 0;
    int          op_chk_cyc = -1;
    logic [70:0] exp_ops;

    // Reference model: who should be granted and when/what should complete.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 0;
            m_rr = 0;
            sb.delete();
            op_chk_cyc = -1;
        end else begin
            if (m_busy && cyc == m_done) m_busy = 0;
            if (!m_busy) begin
                logic [N-1:0] exp_g;
                exp_g = '0;
                if (req_i != '0) begin
                    int w, eff;
                    bit timed;
                    exp_t ent;
                    w = -1;
                    for (int k = 0; k < N; k++)
                        if (w < 0 && req_i[(m_rr + k) % N]) w = (m_rr + k) % N;
                    exp_g[w] = 1'b1;
                    gnt_seen[w] = 1'b1;
                    timed = !(lat_r[w] != 0 && lat_r[w] <= TO);
                    eff = timed ? TO : lat_r[w];
                    ent.onehot = exp_g;
                    ent.err = timed;
                    ent.result = timed ? 32'd0 :
                        fpu_fn(operand_a_i[w*32 +: 32], operand_b_i[w*32 +: 32],
                               operator_i[w*4 +: 4], rounding_mode_i[w*3 +: 3]);
                    ent.cyc = cyc + eff + 1;
                    sb.push_back(ent);
                    exp_ops = {operand_a_i[w*32 +: 32], operand_b_i[w*32 +: 32],
                               rounding_mode_i[w*3 +: 3], operator_i[w*4 +: 4]};
                    op_chk_cyc = cyc + 1;
                    m_busy = 1;
                    m_done = cyc + eff + 1;
                    m_rr = (w + 1) % N;
                    cur_lat = lat_r[w];
                end
                check("gnt_idle", gnt_o, exp_g);
                check("enable_idle", {fpu_enable_o, busy_o}, 2'b00);
            end else begin
                check("gnt_busy", gnt_o, '0);
                check("enable_busy", {fpu_enable_o, busy_o, fpu_stall_o}, 3'b110);
                if (cyc == op_chk_cyc)
                    check("fpu_operands", {fpu_operand_a_o, fpu_operand_b_o, fpu_rm_o, fpu_op_o}, exp_ops);
            end
        end
    end

    // Monitor: compares every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rvalid_in_reset", {rvalid_o, err_o}, '0);
        end else begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_rvalid: got nothing at cycle %0d expected rvalid %0h", sb[0].cyc, sb[0].onehot);
                void'(sb.pop_front());
            end
            if (rvalid_o != '0 || err_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_rvalid", {rvalid_o, err_o}, '0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rvalid", rvalid_o, e.onehot);
                    check("result", result_o, e.result);
                    check("err", err_o, e.err);
                    check("rvalid_cycle", cyc, e.cyc);
                    $display("txn cycle %0d rvalid %b result %h err %0d", cyc, rvalid_o, result_o, err_o);
                end
            end
        end
    end

    // FPU model: valid after cur_lat enabled cycles; noise on valid/result while idle.
    int fcnt = 0;
    always @(posedge clk) begin
        #1;
        if (fpu_enable_o) begin
            fcnt++;
            fpu_valid_i = (cur_lat != 0 && fcnt == cur_lat);
            fpu_result_i = fpu_valid_i ? fpu_fn(fpu_operand_a_o, fpu_operand_b_o, fpu_op_o, fpu_rm_o) : $urandom;
        end else begin
            fcnt = 0;
            fpu_valid_i = 1'($urandom_range(0, 1));
            fpu_result_i = $urandom;
        end
    end

    task automatic rand_ops(input int i);
        operand_a_i[i*32 +: 32] = $urandom;
        operand_b_i[i*32 +: 32] = $urandom;
        rounding_mode_i[i*3 +: 3] = 3'($urandom_range(0, 7));
        operator_i[i*4 +: 4] = 4'($urandom_range(0, 3));
    endtask

    // Raise mask, drop each request after its grant.
    task automatic run(input logic [N-1:0] mask);
        int n;
        gnt_seen = '0;
        req_i = req_i | mask;
        n = 0;
        while (req_i != '0 && n < 200) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++)
                if (gnt_seen[i]) begin gnt_seen[i] = 1'b0; req_i[i] = 1'b0; end
            n++;
        end
        if (req_i != '0) check("run_grant_timeout", req_i, '0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_busy || sb.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (m_busy || sb.size() != 0) check("idle_timeout", sb.size(), 0);
    endtask

    initial begin
        int order[$];
        int n;
        rst_n = 1'b0;
        req_i = '0;
        operand_a_i = '0; operand_b_i = '0; rounding_mode_i = '0; operator_i = '0;
        fpu_result_i = '0; fpu_valid_i = 1'b0;
        for (int i = 0; i < N; i++) lat_r[i] = 2;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {gnt_o, rvalid_o, result_o, err_o, busy_o, fpu_enable_o, fpu_stall_o}, '0);
        check("reset_fpu_regs", {fpu_operand_a_o, fpu_operand_b_o, fpu_rm_o, fpu_op_o}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single add from requester 2: 1.0 + 2.0.
        operand_a_i[2*32 +: 32] = 32'h3F800000;
        operand_b_i[2*32 +: 32] = 32'h40000000;
        operator_i[2*4 +: 4] = 4'd0;
        rounding_mode_i[2*3 +: 3] = 3'd0;
        run(4'b0100);
        wait_idle();
        check("add_result", {result_o, err_o}, {32'h40400000, 1'b0});

        // Pointer now at 3: only requester 1 -> grant 1, then 3 and 0.
        for (int i = 0; i < N; i++) rand_ops(i);
        run(4'b0010);
        wait_idle();
        run(4'b1001);
        wait_idle();

        // Timeout on requester 0 while requester 1 waits for the completion cycle.
        lat_r[0] = 0;
        run(4'b0001);
        req_i[1] = 1'b1;
        run(4'b0010);
        wait_idle();
        lat_r[0] = 2;

        // Valid arrives exactly at the timeout cycle.
        lat_r[2] = TO;
        run(4'b0100);
        wait_idle();
        lat_r[2] = 2;

        // Reset one cycle after grant.
        gnt_seen = '0;
        req_i = 4'b0100;
        n = 0;
        while (!gnt_seen[2] && n < 50) begin @(posedge clk); #1; n++; end
        check("reset_test_grant", gnt_seen[2], 1'b1);
        req_i = '0;
        rst_n = 1'b0;
        #1;
        check("reset_mid_busy", {fpu_enable_o, rvalid_o, busy_o}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Round robin with all requests held: expect 0,1,2,3,0,1,2,3.
        gnt_seen = '0;
        req_i = '1;
        n = 0;
        while (order.size() < 8 && n < 100) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++)
                if (gnt_seen[i]) begin gnt_seen[i] = 1'b0; order.push_back(i); end
            n++;
        end
        req_i = '0;
        check("rr_count", order.size(), 8);
        for (int k = 0; k < order.size(); k++) check("rr_order", order[k], k % N);
        wait_idle();

        // Random traffic with withdrawals, re-requests and mixed latencies.
        gnt_seen = '0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (gnt_seen[i]) begin
                    gnt_seen[i] = 1'b0;
                    req_i[i] = 1'b0;
                end else if (req_i[i] && $urandom_range(0, 29) == 0) begin
                    req_i[i] = 1'b0;
                end else if (!req_i[i] && $urandom_range(0, 3) == 0) begin
                    int pick;
                    rand_ops(i);
                    pick = $urandom_range(0, 19);
                    lat_r[i] = (pick < 16) ? 1 + pick % 4 : (pick == 16) ? TO : (pick == 17) ? TO + 1 : 0;
                    req_i[i] = 1'b1;
                end
            end
        end
        req_i = '0;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
